// File: rtl/usb_fs_out_ep_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_fs_out_ep_buffer_if                                                  |
// | Receiver packet events, consumer read port and handshake request bundle. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface usb_fs_out_ep_buffer_if;
  logic [6:0] dev_addr;
  logic       pkt_start;
  logic       pkt_end;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       valid_packet;
  logic       rx_data_put;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       pkt_committed;
  logic       last_setup;
  logic       hs_req;
  logic       hs_ack;

  modport master (
    output dev_addr, pkt_start, pkt_end, pid, addr, endp, valid_packet,
    output rx_data_put, rx_data, rd_en,
    input  rd_data, rd_empty, pkt_committed, last_setup, hs_req, hs_ack
  );

  modport slave (
    input  dev_addr, pkt_start, pkt_end, pid, addr, endp, valid_packet,
    input  rx_data_put, rx_data, rd_en,
    output rd_data, rd_empty, pkt_committed, last_setup, hs_req, hs_ack
  );
endinterface
`default_nettype wire

// File: rtl/usb_fs_out_ep_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_fs_out_ep_buffer                                                     |
// | OUT/SETUP endpoint byte FIFO with speculative write, CRC strip, ACK/NAK. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module usb_fs_out_ep_buffer #(
  parameter int EP    = 0,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  usb_fs_out_ep_buffer_if.slave bus
);

  localparam logic [3:0]  c_pid_out   = 4'b0001;
  localparam logic [3:0]  c_pid_setup = 4'b1101;
  localparam logic [3:0]  c_pid_data0 = 4'b0011;
  localparam logic [3:0]  c_pid_data1 = 4'b1011;
  localparam logic [3:0]  c_ep        = 4'(EP);
  localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_crc_len   = (AW+1)'(2);
  localparam logic [AW+1:0] c_cnt_max = (AW+2)'(DEPTH + 2);
  localparam logic [AW+1:0] c_cnt_min = (AW+2)'(2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EVAL_TOK  = 3'd1,
    ARMED     = 3'd2,
    RECV      = 3'd3,
    EVAL_DATA = 3'd4
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_cm_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [AW+1:0]   r_byte_cnt;
  logic            r_data_toggle;
  logic            r_overflow;
  logic            r_is_setup;
  logic            r_last_setup;
  logic            r_hs_req;
  logic            r_hs_ack;
  logic            r_pkt_committed;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_pop;
  logic w_tok_match;
  logic w_data_ok;

  assign w_empty = (r_rd_ptr == r_cm_ptr);
  // Full counts speculative bytes too, so an uncommitted packet can never overwrite unread data.
  assign w_full  = ((r_wr_ptr - r_rd_ptr) == c_depth);
  assign w_wr_en = (r_state == RECV) && bus.rx_data_put && !w_full;
  assign w_pop   = bus.rd_en && !w_empty;

  assign w_tok_match = bus.valid_packet
                    && ((bus.pid == c_pid_out) || (bus.pid == c_pid_setup))
                    && (bus.addr == bus.dev_addr)
                    && (bus.endp == c_ep);

  assign w_data_ok = bus.valid_packet
                  && ((bus.pid == c_pid_data0) || (bus.pid == c_pid_data1))
                  && (r_byte_cnt >= c_cnt_min);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.rx_data;
    end
  end

  assign bus.rd_data       = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.rd_empty      = w_empty;
  assign bus.pkt_committed = r_pkt_committed;
  assign bus.last_setup    = r_last_setup;
  assign bus.hs_req        = r_hs_req;
  assign bus.hs_ack        = r_hs_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_wr_ptr        <= '0;
      r_cm_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_byte_cnt      <= '0;
      r_data_toggle   <= 1'b0;
      r_overflow      <= 1'b0;
      r_is_setup      <= 1'b0;
      r_last_setup    <= 1'b0;
      r_hs_req        <= 1'b0;
      r_hs_ack        <= 1'b0;
      r_pkt_committed <= 1'b0;
    end else begin
      r_hs_req        <= 1'b0;
      r_pkt_committed <= 1'b0;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.pkt_end) r_state <= EVAL_TOK;
        end
        EVAL_TOK: begin
          if (w_tok_match) begin
            r_state    <= ARMED;
            r_is_setup <= (bus.pid == c_pid_setup);
            if (bus.pid == c_pid_setup) r_data_toggle <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        ARMED: begin
          if (bus.pkt_start) begin
            r_state    <= RECV;
            r_overflow <= 1'b0;
            r_byte_cnt <= '0;
            r_wr_ptr   <= r_cm_ptr;
          end else if (bus.pkt_end) begin
            r_state <= EVAL_TOK;
          end
        end
        RECV: begin
          if (bus.rx_data_put) begin
            if (w_full) r_overflow <= 1'b1;
            else        r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (r_byte_cnt != c_cnt_max) r_byte_cnt <= r_byte_cnt + 1'b1;
          end
          if (bus.pkt_end) r_state <= EVAL_DATA;
        end
        EVAL_DATA: begin
          r_state <= IDLE;
          if (!w_data_ok) begin
            r_wr_ptr <= r_cm_ptr;
          end else if (r_overflow) begin
            r_wr_ptr <= r_cm_ptr;
            r_hs_req <= 1'b1;
            r_hs_ack <= 1'b0;
          end else if (bus.pid[3] != r_data_toggle) begin
            // Retransmission of an already accepted packet: ACK it but keep the FIFO as is.
            r_wr_ptr <= r_cm_ptr;
            r_hs_req <= 1'b1;
            r_hs_ack <= 1'b1;
          end else begin
            r_cm_ptr        <= r_wr_ptr - c_crc_len;
            r_wr_ptr        <= r_wr_ptr - c_crc_len;
            r_data_toggle   <= ~r_data_toggle;
            r_pkt_committed <= 1'b1;
            r_last_setup    <= r_is_setup;
            r_hs_req        <= 1'b1;
            r_hs_ack        <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_out_ep_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_fs_out_ep_buffer                                                  |
// | Directed bench with a transaction-level endpoint model and literal pins. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_usb_fs_out_ep_buffer;
  localparam int EP    = 2;
  localparam int DEPTH = 16;
  localparam logic [6:0] DEV = 7'd5;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic run = 1'b0;

  usb_fs_out_ep_buffer_if bus ();

  usb_fs_out_ep_buffer #(.EP(EP), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Transaction-level model of the endpoint
  bq_t  mq;
  logic m_toggle, m_armed, m_is_setup;
  logic m_hs_req, m_hs_ack, m_commit, m_last_setup;

  task automatic model_reset();
    mq.delete();
    m_toggle = 0; m_armed = 0; m_is_setup = 0;
    m_hs_req = 0; m_hs_ack = 0; m_commit = 0; m_last_setup = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("hs_req", {31'd0, bus.hs_req}, {31'd0, m_hs_req});
      chk("hs_ack", {31'd0, bus.hs_ack}, {31'd0, m_hs_ack});
      chk("pkt_committed", {31'd0, bus.pkt_committed}, {31'd0, m_commit});
      chk("last_setup", {31'd0, bus.last_setup}, {31'd0, m_last_setup});
      chk("rd_empty", {31'd0, bus.rd_empty}, {31'd0, (mq.size() == 0)});
      if (mq.size() != 0) chk("rd_data", {24'd0, bus.rd_data}, {24'd0, mq[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input logic v);
    tick(); bus.pkt_start = 1;
    tick(); bus.pkt_start = 0;
    tick(); bus.pkt_end = 1; bus.pid = p; bus.addr = a; bus.endp = e; bus.valid_packet = v;
    tick(); bus.pkt_end = 0;
    tick(); bus.valid_packet = 0;
    // A token arriving while already armed is received as a (bad) data packet.
    if (m_armed) m_armed = 0;
    else begin
      m_armed = v && (p == 4'b0001 || p == 4'b1101) && a == DEV && e == 4'(EP);
      if (m_armed) begin
        m_is_setup = (p == 4'b1101);
        if (m_is_setup) m_toggle = 0;
      end
    end
  endtask

  task automatic send_bytes(input bq_t d);
    foreach (d[i]) begin
      bus.rx_data_put = 1; bus.rx_data = d[i];
      tick(); bus.rx_data_put = 0;
      tick();
    end
  endtask

  task automatic finish_data(input logic [3:0] p, input bq_t d, input logic v,
                             output logic g_req, output logic g_ack, output logic g_cm);
    int n;
    n = d.size();
    bus.pkt_end = 1; bus.pid = p; bus.valid_packet = v;
    tick(); bus.pkt_end = 0;
    tick();
    g_req = bus.hs_req; g_ack = bus.hs_ack; g_cm = bus.pkt_committed;
    if (m_armed) begin
      m_armed = 0;
      if (!v || !(p == 4'b0011 || p == 4'b1011) || n < 2) begin
      end else if (mq.size() + n > DEPTH) begin
        m_hs_req = 1; m_hs_ack = 0;
      end else if (p[3] != m_toggle) begin
        m_hs_req = 1; m_hs_ack = 1;
      end else begin
        for (int i = 0; i < n - 2; i++) mq.push_back(d[i]);
        m_toggle = ~m_toggle; m_commit = 1; m_last_setup = m_is_setup;
        m_hs_req = 1; m_hs_ack = 1;
      end
    end
    tick(); bus.valid_packet = 0;
    m_hs_req = 0; m_commit = 0;
  endtask

  task automatic send_data(input logic [3:0] p, input bq_t d, input logic v,
                           output logic g_req, output logic g_ack, output logic g_cm);
    tick(); bus.pkt_start = 1;
    tick(); bus.pkt_start = 0;
    send_bytes(d);
    finish_data(p, d, v, g_req, g_ack, g_cm);
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp);
    bus.rd_en = 1;
    chk(name, {24'd0, bus.rd_data}, {24'd0, exp});
    tick(); bus.rd_en = 0;
    if (mq.size() != 0) void'(mq.pop_front());
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t  pl, part;
    logic gr, ga, gc;
    bus.dev_addr = DEV; bus.pkt_start = 0; bus.pkt_end = 0; bus.pid = 0;
    bus.addr = 0; bus.endp = 0; bus.valid_packet = 0; bus.rx_data_put = 0;
    bus.rx_data = 0; bus.rd_en = 0;
    model_reset();
    #1;
    run = 1;
    chk("reset_rd_empty", {31'd0, bus.rd_empty}, 32'd1);
    chk("reset_hs_req", {31'd0, bus.hs_req}, 32'd0);
    tick(); tick(); reset = 0;
    tick();

    // Basic OUT + DATA0 commit, then drain
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h11, 8'h22, 8'h33, 8'hab, 8'hcd};
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t1_req", {31'd0, gr}, 32'd1);
    chk("t1_ack", {31'd0, ga}, 32'd1);
    chk("t1_commit", {31'd0, gc}, 32'd1);
    read_byte("t1_rd0", 8'h11);
    read_byte("t1_rd1", 8'h22);
    read_byte("t1_rd2", 8'h33);
    chk("t1_empty", {31'd0, bus.rd_empty}, 32'd1);

    // Duplicate DATA0
    send_token(4'b0001, DEV, 4'(EP), 1);
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t2_req", {31'd0, gr}, 32'd1);
    chk("t2_ack", {31'd0, ga}, 32'd1);
    chk("t2_commit", {31'd0, gc}, 32'd0);
    chk("t2_empty", {31'd0, bus.rd_empty}, 32'd1);

    // Token to another address
    send_token(4'b0001, 7'd6, 4'(EP), 1);
    pl = {8'h01, 8'h02, 8'hee, 8'hff};
    send_data(4'b1011, pl, 1, gr, ga, gc);
    chk("t3_req", {31'd0, gr}, 32'd0);
    chk("t3_empty", {31'd0, bus.rd_empty}, 32'd1);

    // DATA1 with 10 bytes left unread
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'h40 + 8'(i));
    send_data(4'b1011, pl, 1, gr, ga, gc);
    chk("t4_commit", {31'd0, gc}, 32'd1);

    // 12 payload + 2 CRC into 6 free bytes -> NAK
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl.delete();
    for (int i = 0; i < 14; i++) pl.push_back(8'h80 + 8'(i));
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t5_req", {31'd0, gr}, 32'd1);
    chk("t5_ack", {31'd0, ga}, 32'd0);
    chk("t5_commit", {31'd0, gc}, 32'd0);
    for (int i = 0; i < 10; i++) read_byte("t5_rd", 8'h40 + 8'(i));
    chk("t5_empty", {31'd0, bus.rd_empty}, 32'd1);

    // Bring toggle to 1, then SETUP forces DATA0
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h5a, 8'h00, 8'h00};
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t6a_commit", {31'd0, gc}, 32'd1);
    read_byte("t6a_rd", 8'h5a);
    send_token(4'b1101, DEV, 4'(EP), 1);
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'hc0 + 8'(i));
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t6_setup_commit", {31'd0, gc}, 32'd1);
    chk("t6_last_setup", {31'd0, bus.last_setup}, 32'd1);
    for (int i = 0; i < 8; i++) read_byte("t6_rd", 8'hc0 + 8'(i));

    // Invalid packet, too-short packet, zero-length packet
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h12, 8'h34};
    send_data(4'b1011, pl, 0, gr, ga, gc);
    chk("t6_invalid_req", {31'd0, gr}, 32'd0);
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h12};
    send_data(4'b1011, pl, 1, gr, ga, gc);
    chk("t6_short_req", {31'd0, gr}, 32'd0);
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h12, 8'h34};
    send_data(4'b1011, pl, 1, gr, ga, gc);
    chk("t6_zlp_commit", {31'd0, gc}, 32'd1);
    chk("t6_zlp_last_setup", {31'd0, bus.last_setup}, 32'd0);
    chk("t6_zlp_empty", {31'd0, bus.rd_empty}, 32'd1);

    // Reset in the middle of a packet
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h77, 8'h88, 8'h00, 8'h00};
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t7_commit", {31'd0, gc}, 32'd1);
    send_token(4'b0001, DEV, 4'(EP), 1);
    tick(); bus.pkt_start = 1;
    tick(); bus.pkt_start = 0;
    part = {8'ha1, 8'ha2, 8'ha3};
    send_bytes(part);
    reset = 1;
    model_reset();
    tick(); tick(); reset = 0;
    chk("t7_rst_empty", {31'd0, bus.rd_empty}, 32'd1);
    chk("t7_rst_req", {31'd0, bus.hs_req}, 32'd0);
    part = {8'ha4, 8'h00, 8'h00};
    send_bytes(part);
    pl = {8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'h00, 8'h00};
    finish_data(4'b1011, pl, 1, gr, ga, gc);
    chk("t7_orphan_req", {31'd0, gr}, 32'd0);
    send_token(4'b0001, DEV, 4'(EP), 1);
    pl = {8'h99, 8'h00, 8'h00};
    send_data(4'b0011, pl, 1, gr, ga, gc);
    chk("t7_after_commit", {31'd0, gc}, 32'd1);
    read_byte("t7_rd", 8'h99);
    chk("t7_end_empty", {31'd0, bus.rd_empty}, 32'd1);

    tick();
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
